// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution control path.
//   - state_t  : sequencer states
//   - CTL_*    : bit positions inside the datapath control bundle
//   - CTL_W    : control bundle width
//   - IMG_*    : interior pixel bounds of the frame
//   - TMR_W    : width of the memory-latency wait counter
package conv_pkg;

    localparam int CTL_W = 23;

    localparam int CTL_EN_KEY         = 0;
    localparam int CTL_S_KEY          = 1;
    localparam int CTL_EN_INC_KER     = 2;
    localparam int CTL_S_INC_KER      = 3;
    localparam int CTL_EN_KER_ADDR    = 4;
    localparam int CTL_S_KER_ADDR     = 5;
    localparam int CTL_EN_READ_PIX    = 6;
    localparam int CTL_S_READ_PIX     = 7;
    localparam int CTL_EN_RST_INC_PIX = 8;
    localparam int CTL_EN_INC_PIX     = 9;
    localparam int CTL_S_INC_PIX      = 10;
    localparam int CTL_EN_RST_NINE    = 11;
    localparam int CTL_EN_INC_NINE    = 12;
    localparam int CTL_S_INC_NINE     = 13;
    localparam int CTL_EN_LOAD_NINE   = 14;
    localparam int CTL_S_LOAD_NINE    = 15;
    localparam int CTL_EN_RST_SUMNINE = 16;
    localparam int CTL_EN_INC_SUM     = 17;
    localparam int CTL_S_INC_SUM      = 18;
    localparam int CTL_EN_APPLY_KER   = 19;
    localparam int CTL_S_APPLY_KER    = 20;
    localparam int CTL_EN_FINAL_KER   = 21;
    localparam int CTL_S_FINAL_KER    = 22;

    // Interior pixels run 1..119 in both dimensions (121x121 frame).
    localparam int IMG_MIN = 1;
    localparam int IMG_MAX = 119;

    localparam int TMR_W = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KEY,
        ST_KER_INIT,
        ST_KER_WAIT,
        ST_KER_CAP,
        ST_PIX_INIT,
        ST_NB_INIT,
        ST_NB_WAIT,
        ST_NB_CAP,
        ST_SUM_INIT,
        ST_SUM,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/conv_sequencer_lat_timer.sv
// lat_timer: loadable down-counter that paces the memory wait states.
//   clk, rst_n : clock, async active-low reset (counter -> 0)
//   load       : load 'value' this cycle (takes priority over counting)
//   value      : reload value
//   zero       : counter is 0 (the wait is over)
// When not loading the counter decrements until it reaches 0 and then holds.
module lat_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: control FSM for the image-convolution datapath.
// Sequence per frame: key read, 9-tap kernel load, then for every interior
// pixel a 3x3 neighbourhood load, 9-step MAC and a write-back.
//   clk, rst_n        : clock, async active-low reset
//   start             : frame request, honoured only in IDLE
//   abort             : cancel the frame from any non-IDLE state
//   ker_final_addr    : last kernel tap addressed (sampled in KER_CAP)
//   pix_final_addr    : last interior pixel addressed (sampled in NEXT)
//   nine_flag         : last neighbourhood tap addressed (sampled in NB_CAP)
//   sum_flag          : last MAC step (sampled in SUM)
//   ctl               : datapath control bundle, decoded from state + flags
//   busy              : not IDLE
//   done              : one-cycle pulse after the last write-back
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ker_final_addr,
    input  logic             pix_final_addr,
    input  logic             nine_flag,
    input  logic             sum_flag,
    output logic [CTL_W-1:0] ctl,
    output logic             busy,
    output logic             done
);

    // WAIT states last MEM_LAT cycles: the timer is loaded with MEM_LAT-1 on
    // the way in and the WAIT state exits on the cycle it reads zero.
    localparam logic [TMR_W-1:0] LAT_LD = TMR_W'(MEM_LAT - 1);

    state_t           r_state;
    state_t           w_nxt;
    logic [CTL_W-1:0] w_ctl;
    logic             w_load;
    logic             w_zero;
    logic             w_done;

    lat_timer #(
        .W (TMR_W)
    ) u_lat_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .value (LAT_LD),
        .zero  (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt  = r_state;
        w_ctl  = '0;
        w_load = 1'b0;
        w_done = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !abort) w_nxt = ST_KEY;
            end
            ST_KEY: begin
                w_ctl[CTL_EN_KEY] = 1'b1;
                w_ctl[CTL_S_KEY]  = 1'b1;
                w_nxt             = ST_KER_INIT;
            end
            ST_KER_INIT: begin
                // inc_ker with select low clears the kernel address
                w_ctl[CTL_EN_INC_KER] = 1'b1;
                w_load                = 1'b1;
                w_nxt                 = ST_KER_WAIT;
            end
            ST_KER_WAIT: begin
                if (w_zero) w_nxt = ST_KER_CAP;
            end
            ST_KER_CAP: begin
                w_ctl[CTL_EN_KER_ADDR] = 1'b1;
                w_ctl[CTL_S_KER_ADDR]  = 1'b1;
                if (!ker_final_addr) begin
                    w_ctl[CTL_EN_INC_KER] = 1'b1;
                    w_ctl[CTL_S_INC_KER]  = 1'b1;
                    w_load                = 1'b1;
                    w_nxt                 = ST_KER_WAIT;
                end else begin
                    w_nxt = ST_PIX_INIT;
                end
            end
            ST_PIX_INIT: begin
                // read_pix with select low parks the pixel address at (1,1)
                w_ctl[CTL_EN_READ_PIX] = 1'b1;
                w_nxt                  = ST_NB_INIT;
            end
            ST_NB_INIT: begin
                w_ctl[CTL_EN_RST_INC_PIX] = 1'b1;
                w_ctl[CTL_EN_RST_NINE]    = 1'b1;
                w_load                    = 1'b1;
                w_nxt                     = ST_NB_WAIT;
            end
            ST_NB_WAIT: begin
                if (w_zero) w_nxt = ST_NB_CAP;
            end
            ST_NB_CAP: begin
                w_ctl[CTL_EN_LOAD_NINE] = 1'b1;
                w_ctl[CTL_S_LOAD_NINE]  = 1'b1;
                if (!nine_flag) begin
                    w_ctl[CTL_EN_INC_NINE] = 1'b1;
                    w_ctl[CTL_S_INC_NINE]  = 1'b1;
                    w_ctl[CTL_EN_INC_PIX]  = 1'b1;
                    w_ctl[CTL_S_INC_PIX]   = 1'b1;
                    w_load                 = 1'b1;
                    w_nxt                  = ST_NB_WAIT;
                end else begin
                    w_nxt = ST_SUM_INIT;
                end
            end
            ST_SUM_INIT: begin
                w_ctl[CTL_EN_APPLY_KER]   = 1'b1;
                w_ctl[CTL_EN_RST_SUMNINE] = 1'b1;
                w_nxt                     = ST_SUM;
            end
            ST_SUM: begin
                w_ctl[CTL_EN_APPLY_KER] = 1'b1;
                w_ctl[CTL_S_APPLY_KER]  = 1'b1;
                if (!sum_flag) begin
                    w_ctl[CTL_EN_INC_SUM] = 1'b1;
                    w_ctl[CTL_S_INC_SUM]  = 1'b1;
                end else begin
                    w_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_ctl[CTL_EN_FINAL_KER] = 1'b1;
                w_ctl[CTL_S_FINAL_KER]  = 1'b1;
                w_nxt                   = ST_NEXT;
            end
            ST_NEXT: begin
                w_ctl[CTL_EN_FINAL_KER] = 1'b1;
                if (pix_final_addr) begin
                    w_nxt = ST_DONE;
                end else begin
                    w_ctl[CTL_EN_READ_PIX] = 1'b1;
                    w_ctl[CTL_S_READ_PIX]  = 1'b1;
                    w_nxt                  = ST_NB_INIT;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_nxt  = ST_IDLE;
            end
            default: begin
                w_nxt = ST_IDLE;
            end
        endcase

        // Abort wins over everything: drop to IDLE and force datapath we low.
        if (abort && (r_state != ST_IDLE)) begin
            w_ctl                   = '0;
            w_ctl[CTL_EN_FINAL_KER] = 1'b1;
            w_load                  = 1'b0;
            w_done                  = 1'b0;
            w_nxt                   = ST_IDLE;
        end
    end

    assign ctl  = w_ctl;
    assign done = w_done;
    assign busy = (r_state != ST_IDLE);

endmodule
